// File: rtl/led_ctrl.sv
// Front-panel LED sequencer: error blink codes over stretched activity
// over power level with optional PWM dimming; active-low registered drive.
module led_ctrl #(
   parameter int          PWM_BITS       = 4,
   parameter int          DIM_DUTY       = 4,
   parameter logic [15:0] STRETCH_CYCLES = 16'd50000,
   parameter logic [19:0] BLINK_CYCLES   = 20'd400000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       POWER,
   input  logic       DIM,
   input  logic       ACT,
   input  logic [3:0] ERR_CODE,
   output logic       _LED,
   output logic       BUSY
);

   typedef enum logic [1:0] {
      IDLE,
      ON,
      OFF,
      GAP
   } state_t;

   // Gap is four blink phases, so the shared counter needs two extra bits.
   localparam logic [21:0] BLINK_LD = {2'b00, BLINK_CYCLES} - 22'd1;
   localparam logic [21:0] GAP_LD   = {BLINK_CYCLES, 2'b00} - 22'd1;

   state_t              state;
   state_t              state_nxt;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic [15:0]         stretch_cnt;
   logic [21:0]         blink_cnt;
   logic [21:0]         blink_nxt;
   logic [3:0]          rep;
   logic [3:0]          rep_nxt;
   logic                dim_on;
   logic                act_on;
   logic                led_on;

   assign dim_on = (int'(pwm_cnt) < DIM_DUTY);
   assign act_on = ACT | (stretch_cnt != 16'd0);

   always_comb begin
      state_nxt = state;
      blink_nxt = blink_cnt;
      rep_nxt   = rep;
      unique case (state)
         IDLE: begin
            if (ERR_CODE != 4'd0) begin
               state_nxt = ON;
               rep_nxt   = ERR_CODE;
               blink_nxt = BLINK_LD;
            end
         end
         ON: begin
            if (blink_cnt == 22'd0) begin
               state_nxt = OFF;
               blink_nxt = BLINK_LD;
            end else begin
               blink_nxt = blink_cnt - 22'd1;
            end
         end
         OFF: begin
            if (blink_cnt == 22'd0) begin
               if (rep != 4'd0) rep_nxt = rep - 4'd1;
               if (rep <= 4'd1) begin
                  state_nxt = GAP;
                  blink_nxt = GAP_LD;
               end else begin
                  state_nxt = ON;
                  blink_nxt = BLINK_LD;
               end
            end else begin
               blink_nxt = blink_cnt - 22'd1;
            end
         end
         GAP: begin
            if (blink_cnt == 22'd0) begin
               if (ERR_CODE != 4'd0) begin
                  state_nxt = ON;
                  rep_nxt   = ERR_CODE;
                  blink_nxt = BLINK_LD;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               blink_nxt = blink_cnt - 22'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      led_on = 1'b0;
      if (state != IDLE)  led_on = (state == ON);
      else if (act_on)    led_on = 1'b1;
      else if (POWER)     led_on = ~DIM | dim_on;
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state       <= IDLE;
         pwm_cnt     <= '0;
         stretch_cnt <= 16'd0;
         blink_cnt   <= 22'd0;
         rep         <= 4'd0;
         _LED        <= 1'b1;
         BUSY        <= 1'b0;
      end else begin
         state     <= state_nxt;
         pwm_cnt   <= pwm_cnt + 1'b1;
         blink_cnt <= blink_nxt;
         rep       <= rep_nxt;
         _LED      <= ~led_on;
         BUSY      <= (state_nxt != IDLE);
         if (ACT)                       stretch_cnt <= STRETCH_CYCLES;
         else if (stretch_cnt != 16'd0) stretch_cnt <= stretch_cnt - 16'd1;
      end
   end

endmodule

// File: tb/tb_led_ctrl.sv
// Bench for led_ctrl: scenario tasks plus random traffic, checked against
// a sequence-time model of the blink code, stretch window and PWM phase.
module tb_led_ctrl;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       POWER = 1'b0;
   logic       DIM = 1'b0;
   logic       ACT = 1'b0;
   logic [3:0] ERR_CODE = 4'd0;
   logic       led;
   logic       busy;

   int checks = 0;
   int errors = 0;

   // Model: blink sequence as elapsed time within one code repetition.
   bit   m_active = 0;
   int   m_t = 0;
   int   m_code = 0;
   int   m_pwm = 0;
   int   m_edge = 0;
   int   m_last = -100;
   logic exp_led = 1'b1;
   logic exp_busy = 1'b0;

   led_ctrl #(
      .PWM_BITS(2),
      .DIM_DUTY(1),
      .STRETCH_CYCLES(16'd8),
      .BLINK_CYCLES(20'd4)
   ) dut (
      .CLK(CLK),
      .RESET(RESET),
      .POWER(POWER),
      .DIM(DIM),
      .ACT(ACT),
      .ERR_CODE(ERR_CODE),
      ._LED(led),
      .BUSY(busy)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      bit act_on;
      bit lit;
      if (RESET) begin
         exp_led  = 1'b1;
         exp_busy = 1'b0;
         m_active = 0;
         m_pwm    = 0;
         m_last   = m_edge - 100;
      end else begin
         act_on = ACT || (m_edge - m_last <= 8);
         if (m_active)    lit = (m_t < 8 * m_code) && (m_t % 8 < 4);
         else if (act_on) lit = 1;
         else if (POWER)  lit = !DIM || (m_pwm < 1);
         else             lit = 0;
         exp_led = !lit;
         if (ACT) m_last = m_edge;
         m_pwm = (m_pwm + 1) % 4;
         if (m_active) begin
            if (m_t == 8 * m_code + 15) begin
               if (ERR_CODE != 0) begin
                  m_code = ERR_CODE;
                  m_t    = 0;
               end else begin
                  m_active = 0;
               end
            end else begin
               m_t++;
            end
         end else if (ERR_CODE != 0) begin
            m_active = 1;
            m_t      = 0;
            m_code   = ERR_CODE;
         end
         exp_busy = m_active;
      end
      m_edge++;
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      ACT = 1'b0;
      ERR_CODE = 4'd0;
      step();
      step();
      RESET = 1'b0;
   endtask

   task automatic test_reset();
      RESET = 1'b1;
      POWER = 1'b1;
      ACT = 1'b1;
      ERR_CODE = 4'd3;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (led !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: led=%b busy=%b want led=1 busy=0",
                     led, busy);
         end
      end
      RESET = 1'b0;
      step();
      checks++;
      if (led !== 1'b0 || busy !== 1'b1 ||
          led !== exp_led || busy !== exp_busy) begin
         errors++;
         $display("FAIL reset_release: led=%b busy=%b want led=0 busy=1",
                  led, busy);
      end
      ACT = 1'b0;
   endtask

   task automatic test_power_dim();
      int lows;
      do_reset();
      POWER = 1'b1;
      DIM = 1'b0;
      for (int i = 0; i < 8; i++) begin
         step();
         checks++;
         if (led !== exp_led || led !== 1'b0) begin
            errors++;
            $display("FAIL power_full: led=%b want %b", led, exp_led);
         end
      end
      DIM = 1'b1;
      step();
      lows = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         checks++;
         if (led !== exp_led) begin
            errors++;
            $display("FAIL power_dim: led=%b want %b", led, exp_led);
         end
         if (led === 1'b0) lows++;
      end
      checks++;
      if (lows != 4) begin
         errors++;
         $display("FAIL dim_duty: lows=%0d want 4", lows);
      end
      POWER = 1'b0;
      step();
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (led !== exp_led || led !== 1'b1) begin
            errors++;
            $display("FAIL power_off: led=%b want 1", led);
         end
      end
   endtask

   task automatic test_stretch();
      int lows;
      do_reset();
      POWER = 1'b0;
      lows = 0;
      for (int i = 0; i < 13; i++) begin
         ACT = (i == 0);
         step();
         checks++;
         if (led !== exp_led) begin
            errors++;
            $display("FAIL stretch_single: cyc=%0d led=%b want %b",
                     i, led, exp_led);
         end
         if (led === 1'b0) lows++;
      end
      checks++;
      if (lows != 9) begin
         errors++;
         $display("FAIL stretch_len: lows=%0d want 9", lows);
      end
      lows = 0;
      for (int i = 0; i < 18; i++) begin
         ACT = (i == 0 || i == 5);
         step();
         checks++;
         if (led !== exp_led) begin
            errors++;
            $display("FAIL stretch_retrig: cyc=%0d led=%b want %b",
                     i, led, exp_led);
         end
         if (led === 1'b0) lows++;
      end
      ACT = 1'b0;
      checks++;
      if (lows != 14) begin
         errors++;
         $display("FAIL stretch_retrig_len: lows=%0d want 14", lows);
      end
   endtask

   task automatic test_blink2();
      int lows;
      do_reset();
      ERR_CODE = 4'd2;
      lows = 0;
      for (int i = 0; i < 72; i++) begin
         ACT = 1'($urandom_range(0, 1));
         POWER = 1'($urandom_range(0, 1));
         DIM = 1'($urandom_range(0, 1));
         step();
         checks++;
         if (led !== exp_led || busy !== exp_busy) begin
            errors++;
            $display("FAIL blink2: cyc=%0d led=%b busy=%b want %b %b",
                     i, led, busy, exp_led, exp_busy);
         end
         if (i >= 1 && i <= 64 && led === 1'b0) lows++;
      end
      checks++;
      if (lows != 16) begin
         errors++;
         $display("FAIL blink2_on_count: lows=%0d want 16", lows);
      end
      ACT = 1'b0;
   endtask

   task automatic test_clear();
      do_reset();
      POWER = 1'b1;
      DIM = 1'b1;
      ERR_CODE = 4'd3;
      for (int i = 0; i < 60; i++) begin
         if (i == 10) ERR_CODE = 4'd0;
         step();
         checks++;
         if (led !== exp_led || busy !== exp_busy) begin
            errors++;
            $display("FAIL clear_mid: cyc=%0d led=%b busy=%b want %b %b",
                     i, led, busy, exp_led, exp_busy);
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL clear_idle: busy=%b want 0", busy);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      POWER = 1'b1;
      DIM = 1'b0;
      ERR_CODE = 4'd1;
      repeat (7) step();
      RESET = 1'b1;
      step();
      checks++;
      if (led !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid: led=%b busy=%b want 1 0", led, busy);
      end
      RESET = 1'b0;
      for (int i = 0; i < 30; i++) begin
         step();
         checks++;
         if (led !== exp_led || busy !== exp_busy) begin
            errors++;
            $display("FAIL reset_restart: cyc=%0d led=%b busy=%b want %b %b",
                     i, led, busy, exp_led, exp_busy);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         RESET = ($urandom_range(0, 299) == 0);
         ACT = ($urandom_range(0, 11) == 0);
         if ($urandom_range(0, 19) == 0) POWER = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 19) == 0) DIM = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 59) == 0)
            ERR_CODE = ($urandom_range(0, 1) == 0) ?
                       4'd0 : 4'($urandom_range(1, 15));
         step();
         checks++;
         if (led !== exp_led || busy !== exp_busy) begin
            errors++;
            $display("FAIL random: cyc=%0d led=%b busy=%b want %b %b",
                     i, led, busy, exp_led, exp_busy);
         end
      end
      RESET = 1'b0;
   endtask

   initial begin
      test_reset();
      test_power_dim();
      test_stretch();
      test_blink2();
      test_clear();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
